// File: rtl/mac_accumulator.sv
// mac_accumulator: streaming multiply-accumulate for one neuron.
// Accumulates VEC_LEN unsigned activation/weight products and the activation
// sum. It then holds both totals until the downstream stage takes them.
module mac_accumulator #(
  parameter int PRECISION      = 8,
  parameter int BIAS_PRECISION = 32,
  parameter int VEC_LEN        = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PRECISION-1:0]      in_act,
  input  logic [PRECISION-1:0]      in_wgt,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      ce,
  output logic [BIAS_PRECISION-1:0] acc,
  output logic [BIAS_PRECISION-1:0] ai,
  output logic                      err
);

  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CNT_W-1:0]          r_count;
  logic [BIAS_PRECISION-1:0] r_acc;
  logic [BIAS_PRECISION-1:0] r_ai;
  logic                      r_err;

  logic                      w_accept;
  logic                      w_at_last;
  logic [2*PRECISION-1:0]    w_act_ext;
  logic [2*PRECISION-1:0]    w_wgt_ext;
  logic [2*PRECISION-1:0]    w_prod;
  logic [BIAS_PRECISION-1:0] w_prod_bp;
  logic [BIAS_PRECISION-1:0] w_act_bp;

  // Acceptance depends on registered state only, never on in_valid feeding in_ready.
  assign w_accept  = in_valid & (r_state != S_HOLD);
  assign w_at_last = (r_count == LAST_IDX);

  // Unsigned product at full 2*PRECISION width, then zero-extended; sums wrap.
  assign w_act_ext = {{PRECISION{1'b0}}, in_act};
  assign w_wgt_ext = {{PRECISION{1'b0}}, in_wgt};
  assign w_prod    = w_act_ext * w_wgt_ext;
  assign w_prod_bp = {{(BIAS_PRECISION - 2*PRECISION){1'b0}}, w_prod};
  assign w_act_bp  = {{(BIAS_PRECISION - PRECISION){1'b0}}, in_act};

  assign acc = r_acc;
  assign ai  = r_ai;
  assign err = r_err;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake decode; the beat counter, not in_last, ends a vector.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    ce          = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = (VEC_LEN == 1) ? S_HOLD : S_ACC;
      end
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid && w_at_last) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          ce          = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Accumulators, beat counter and sticky framing flag; the first beat overwrites old totals.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_acc   <= '0;
      r_ai    <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      if (r_state == S_IDLE) begin
        r_acc   <= w_prod_bp;
        r_ai    <= w_act_bp;
        r_count <= CNT_W'(1);
      end else begin
        r_acc   <= r_acc + w_prod_bp;
        r_ai    <= r_ai + w_act_bp;
        r_count <= r_count + CNT_W'(1);
      end
      if (in_last != w_at_last) r_err <= 1'b1;
    end else if (r_state == S_HOLD && out_ready) begin
      r_count <= '0;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: VEC_LEN=4 instance plus a VEC_LEN=1 instance.
module tb_mac_accumulator;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, ce, err;
  logic [7:0]  in_act, in_wgt;
  logic [31:0] acc, ai;

  logic        v1_in_valid, v1_in_ready, v1_in_last, v1_out_valid, v1_ce, v1_err;
  logic [7:0]  v1_in_act, v1_in_wgt;
  logic [31:0] v1_acc, v1_ai;

  int n_checks = 0;
  int n_errors = 0;

  mac_accumulator #(.PRECISION(8), .BIAS_PRECISION(32), .VEC_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .ce(ce),
    .acc(acc), .ai(ai), .err(err)
  );

  mac_accumulator #(.PRECISION(8), .BIAS_PRECISION(32), .VEC_LEN(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(v1_in_valid), .in_ready(v1_in_ready), .in_act(v1_in_act), .in_wgt(v1_in_wgt),
    .in_last(v1_in_last), .out_valid(v1_out_valid), .out_ready(1'b1), .ce(v1_ce),
    .acc(v1_acc), .ai(v1_ai), .err(v1_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] a;
    logic [3:0][7:0] w;
    logic [31:0]     exp_acc;
    logic [31:0]     exp_ai;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Called at a negedge; the beat is taken at the following posedge.
  task automatic beat(input logic [7:0] a, input logic [7:0] w, input logic last);
    in_valid = 1'b1;
    in_act   = a;
    in_wgt   = w;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    vecs[0].a = {8'd4, 8'd3, 8'd2, 8'd1};       vecs[0].w = {8'd40, 8'd30, 8'd20, 8'd10};
    vecs[0].exp_acc = 32'd300;                  vecs[0].exp_ai = 32'd10;
    vecs[1].a = {8'd255, 8'd255, 8'd255, 8'd255}; vecs[1].w = {8'd255, 8'd255, 8'd255, 8'd255};
    vecs[1].exp_acc = 32'd260100;               vecs[1].exp_ai = 32'd1020;
    vecs[2].a = {8'd1, 8'd1, 8'd1, 8'd1};       vecs[2].w = {8'd1, 8'd1, 8'd1, 8'd1};
    vecs[2].exp_acc = 32'd4;                    vecs[2].exp_ai = 32'd4;
    vecs[3].a = {8'd7, 8'd100, 8'd255, 8'd0};   vecs[3].w = {8'd200, 8'd3, 8'd0, 8'd255};
    vecs[3].exp_acc = 32'd1700;                 vecs[3].exp_ai = 32'd362;
    vecs[4].a = {8'd128, 8'd9, 8'd200, 8'd17};  vecs[4].w = {8'd2, 8'd9, 8'd150, 8'd33};
    vecs[4].exp_acc = 32'd30898;                vecs[4].exp_ai = 32'd354;

    rst = 1'b1; in_valid = 1'b0; in_act = '0; in_wgt = '0; in_last = 1'b0; out_ready = 1'b1;
    v1_in_valid = 1'b0; v1_in_act = '0; v1_in_wgt = '0; v1_in_last = 1'b0;
    repeat (2) @(negedge clk);
    check("rst acc", acc, 0);
    check("rst ai", ai, 0);
    check("rst out_valid", out_valid, 0);
    check("rst ce", ce, 0);
    check("rst in_ready", in_ready, 1);
    check("rst err", err, 0);
    rst = 1'b0;

    // Table vectors, back-to-back with out_ready held high.
    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < 4; b++) beat(vecs[v].a[b], vecs[v].w[b], b == 3);
      check($sformatf("v%0d out_valid", v), out_valid, 1);
      check($sformatf("v%0d ce", v), ce, 1);
      check($sformatf("v%0d in_ready", v), in_ready, 0);
      check($sformatf("v%0d acc", v), acc, vecs[v].exp_acc);
      check($sformatf("v%0d ai", v), ai, vecs[v].exp_ai);
      check($sformatf("v%0d err", v), err, 0);
      @(negedge clk);
      check($sformatf("v%0d idle out_valid", v), out_valid, 0);
      check($sformatf("v%0d idle ce", v), ce, 0);
      check($sformatf("v%0d idle in_ready", v), in_ready, 1);
    end

    // Backpressure: result frozen and offered beats ignored while out_ready is low.
    out_ready = 1'b0;
    beat(8'd5, 8'd6, 1'b0);
    beat(8'd7, 8'd8, 1'b0);
    beat(8'd9, 8'd10, 1'b0);
    beat(8'd11, 8'd12, 1'b1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_act = 8'd99; in_wgt = 8'd99; in_last = 1'b1;
      #1;
      check($sformatf("bp%0d out_valid", k), out_valid, 1);
      check($sformatf("bp%0d in_ready", k), in_ready, 0);
      check($sformatf("bp%0d ce", k), ce, 0);
      check($sformatf("bp%0d acc", k), acc, 308);
      check($sformatf("bp%0d ai", k), ai, 32);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    #1;
    check("bp release ce", ce, 1);
    check("bp release acc", acc, 308);
    @(negedge clk);
    check("bp after ce", ce, 0);
    check("bp after out_valid", out_valid, 0);
    check("bp after in_ready", in_ready, 1);

    // Bubbles between beats do not change the sums.
    begin
      int gaps[4];
      gaps = '{0, 2, 3, 1};
      for (int b = 0; b < 4; b++) begin
        repeat (gaps[b]) begin
          in_act = 8'hAA; in_wgt = 8'h55;
          @(negedge clk);
          check($sformatf("bubble%0d out_valid", b), out_valid, 0);
        end
        beat(vecs[0].a[b], vecs[0].w[b], b == 3);
      end
    end
    check("bubble out_valid", out_valid, 1);
    check("bubble acc", acc, 300);
    check("bubble ai", ai, 10);
    @(negedge clk);

    // Framing error: early in_last sets err, vector still completes on count.
    beat(8'd1, 8'd10, 1'b0);
    check("frame err before", err, 0);
    beat(8'd2, 8'd20, 1'b1);
    check("frame err set", err, 1);
    check("frame still accumulating", out_valid, 0);
    beat(8'd3, 8'd30, 1'b0);
    beat(8'd4, 8'd40, 1'b1);
    check("frame out_valid", out_valid, 1);
    check("frame acc", acc, 300);
    check("frame ai", ai, 10);
    check("frame err hold", err, 1);
    @(negedge clk);
    for (int b = 0; b < 4; b++) beat(8'd1, 8'd1, b == 3);
    check("frame clean acc", acc, 4);
    check("frame err sticky", err, 1);
    @(negedge clk);

    // Reset mid-vector discards partial sums and clears err.
    beat(8'd50, 8'd50, 1'b0);
    beat(8'd60, 8'd60, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst acc", acc, 0);
    check("midrst ai", ai, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst in_ready", in_ready, 1);
    check("midrst err", err, 0);
    rst = 1'b0;
    for (int b = 0; b < 3; b++) beat(8'd1, 8'd1, 1'b0);
    check("midrst not done early", out_valid, 0);
    beat(8'd1, 8'd1, 1'b1);
    check("midrst out_valid", out_valid, 1);
    check("midrst new acc", acc, 4);
    check("midrst new ai", ai, 4);
    check("midrst new err", err, 0);
    @(negedge clk);

    // VEC_LEN=1: every beat is a whole vector.
    v1_in_valid = 1'b1; v1_in_act = 8'd7; v1_in_wgt = 8'd9; v1_in_last = 1'b1;
    @(negedge clk);
    v1_in_valid = 1'b0;
    check("len1 out_valid", v1_out_valid, 1);
    check("len1 ce", v1_ce, 1);
    check("len1 acc", v1_acc, 63);
    check("len1 ai", v1_ai, 7);
    check("len1 err", v1_err, 0);
    @(negedge clk);
    check("len1 idle out_valid", v1_out_valid, 0);
    check("len1 idle in_ready", v1_in_ready, 1);
    v1_in_valid = 1'b1; v1_in_act = 8'd2; v1_in_wgt = 8'd3; v1_in_last = 1'b0;
    @(negedge clk);
    v1_in_valid = 1'b0;
    check("len1 missing last acc", v1_acc, 6);
    check("len1 missing last ai", v1_ai, 2);
    check("len1 missing last err", v1_err, 1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
